// File: rtl/arbitro_receptor_if.sv
// Interface between the UART word receiver and the rest of the system.
// The master side drives the serial line and observes the received word and status.
interface arbitro_receptor_if;
  logic        rx;
  logic [31:0] out;
  logic        rx_Done;
  logic        frame_err;
  logic        busy;

  modport master (output rx, input out, rx_Done, frame_err, busy);
  modport slave  (input rx, output out, rx_Done, frame_err, busy);
endinterface

// File: rtl/arbitro_receptor.sv
// 8N1 UART receiver that assembles four bytes (LSB byte first) into a 32-bit word,
// with stop-bit checking, inter-byte timeout and a one-cycle done strobe.
module arbitro_receptor #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_CLKS = 52080
) (
  input  logic                clk,
  input  logic                reset,
  arbitro_receptor_if.slave   bus
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t      r_state, w_next;
  logic        r_rx_m, r_rx_s;
  logic [1:0]  r_sync_vld;
  logic        r_armed;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  logic [31:0] r_out;
  logic [TW-1:0] r_to_cnt;
  logic        r_done, r_ferr;

  logic w_start, w_tick_half, w_tick_full, w_data_smp;
  logic w_stop_ok, w_stop_err, w_timeout, w_word_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_START;
      S_START: if (w_tick_half) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick_full && r_bit_idx == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_tick_full) w_next = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Event decode; a line low right after reset is ignored until it has been seen high
  always_comb begin
    w_start     = (r_state == S_IDLE) && r_armed && !r_rx_s;
    w_tick_half = (r_clk_cnt == CW'(HALF - 1));
    w_tick_full = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    w_data_smp  = (r_state == S_DATA) && w_tick_full;
    w_stop_ok   = (r_state == S_STOP) && w_tick_full &&  r_rx_s;
    w_stop_err  = (r_state == S_STOP) && w_tick_full && !r_rx_s;
    w_timeout   = (r_state == S_IDLE) && (r_byte_idx != 2'd0) && !w_start &&
                  (r_to_cnt == TW'(TIMEOUT_CLKS - 1));
    w_word_done = w_stop_ok && (r_byte_idx == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_m     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_out      <= '0;
      r_to_cnt   <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_m     <= bus.rx;
      r_rx_s     <= r_rx_m;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_armed    <= r_armed | (r_sync_vld[1] & r_rx_s);

      if ((r_state != w_next) || w_data_smp || r_state == S_IDLE || r_state == S_BREAK)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + 1'b1;

      if (w_start) r_bit_idx <= '0;
      if (w_data_smp) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (w_stop_ok) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= r_shift;
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (w_word_done) r_out <= {r_shift, r_word[23:0]};
      if (w_stop_err || w_timeout) begin
        r_byte_idx <= '0;
        r_word     <= '0;
      end

      if (r_state != S_IDLE || r_byte_idx == 2'd0 || w_start || w_timeout)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;

      r_done <= w_word_done;
      r_ferr <= w_stop_err | w_timeout;
    end
  end

  assign bus.out       = r_out;
  assign bus.rx_Done   = r_done;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != S_IDLE) || (r_byte_idx != 2'd0);
endmodule
